// File: rtl/chart_window.sv
// chart_window: rhythm-chart playback head with lookahead window and auto-miss; CHART_HOLD_EN enables hold tracking
module chart_window #(
  parameter int DEPTH  = 256,
  parameter int TIME_W = 14,
  parameter int WIN    = 4,
  parameter int LATE   = 12,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = TIME_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [EW-1:0]     load_data,
  input  logic              start,
  input  logic [TIME_W-1:0] song_time,
  input  logic              consume,
  output logic [WIN*EW-1:0] win_entry,
  output logic [WIN-1:0]    win_valid,
  output logic [AW-1:0]     head_addr,
  output logic              miss_pulse,
  output logic              hold_active,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic hold_q, hold_d, miss_q, miss_d;
  logic [WIN*EW-1:0] win_entry_q, win_entry_d;
  logic [WIN-1:0] win_valid_q, win_valid_d;
  logic [EW-1:0] head_e, slot_e;
  logic [1:0] ty;
  logic late, adv, blk, v;
  logic [AW:0] slot_a;
  // chart memory is writable only while not playing and is never cleared
  always_ff @(posedge clk)
    if (!rst && load_we && state_q != PLAY) mem[load_addr] <= load_data;
  // head decision reads the head entry directly; late compare is one bit wider so it cannot overflow
  always_comb begin
    head_e = mem[head_q];
    ty = head_e[EW-1:EW-2];
    late = {1'b0, song_time} > ({1'b0, head_e[TIME_W-1:0]} + (TIME_W+1)'(LATE));
    adv = state_q == PLAY && ty != 2'b11 && (consume || late);
    state_d = state_q;
    head_d = head_q;
    hold_d = hold_q;
    miss_d = adv && !consume;
    if (state_q != PLAY) begin
      state_d = start ? PLAY : state_q;
      head_d = start ? '0 : head_q;
      hold_d = start ? 1'b0 : hold_q;
    end else if (ty == 2'b11) begin
      state_d = DONE;
    end else if (adv) begin
      state_d = &head_q ? DONE : PLAY;
      head_d = &head_q ? head_q : head_q + 1'b1;
`ifdef CHART_HOLD_EN
      hold_d = (consume && ty == 2'b01) ? 1'b1 : (ty == 2'b10) ? 1'b0 : hold_q;
`endif
    end
`ifndef CHART_HOLD_EN
    hold_d = 1'b0;
`endif
  end
  // lookahead window: a slot is valid until the array end or an end marker; the marker slot itself is invalid
  always_comb begin
    blk = 1'b0;
    slot_a = '0;
    slot_e = '0;
    v = 1'b0;
    win_entry_d = '0;
    win_valid_d = '0;
    for (int k = 0; k < WIN; k++) begin
      slot_a = (AW+1)'(head_q) + (AW+1)'(k);
      slot_e = mem[slot_a[AW-1:0]];
      v = state_q == PLAY && !blk && !slot_a[AW] && slot_e[EW-1:EW-2] != 2'b11;
      blk = blk | !v;
      win_valid_d[k] = v;
      win_entry_d[k*EW +: EW] = v ? slot_e : '0;
    end
  end
  // state, head, strobes and window registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      head_q <= '0;
      hold_q <= 1'b0;
      miss_q <= 1'b0;
      win_entry_q <= '0;
      win_valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      hold_q <= hold_d;
      miss_q <= miss_d;
      win_entry_q <= win_entry_d;
      win_valid_q <= win_valid_d;
    end
  assign win_entry = win_entry_q;
  assign win_valid = win_valid_q;
  assign head_addr = head_q;
  assign miss_pulse = miss_q;
  assign hold_active = hold_q;
  assign busy = state_q == PLAY;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_chart_window.sv
// tb_chart_window: scoreboard bench for chart_window (DEPTH=8, WIN=4, LATE=12)
module tb_chart_window;
  localparam int DEPTH = 8, TIME_W = 14, WIN = 4, LATE = 12, AW = 3, EW = 16;
  logic clk = 0, rst = 1, load_we = 0, start = 0, consume = 0;
  logic [AW-1:0] load_addr = '0;
  logic [EW-1:0] load_data = '0;
  logic [TIME_W-1:0] song_time = '0;
  logic [WIN*EW-1:0] win_entry;
  logic [WIN-1:0] win_valid;
  logic [AW-1:0] head_addr;
  logic miss_pulse, hold_active, busy, done;
  typedef struct {logic miss; logic [AW-1:0] head; logic done;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  chart_window #(.DEPTH(DEPTH), .TIME_W(TIME_W), .WIN(WIN), .LATE(LATE)) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .song_time(song_time), .consume(consume), .win_entry(win_entry),
    .win_valid(win_valid), .head_addr(head_addr), .miss_pulse(miss_pulse),
    .hold_active(hold_active), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task load(input int a, input logic [1:0] t, input int tick);
    @(negedge clk);
    load_we = 1; load_addr = a[AW-1:0]; load_data = {t, tick[TIME_W-1:0]};
    @(negedge clk);
    load_we = 0;
  endtask

  task load_chart_a;
    load(0, 2'b00, 10); load(1, 2'b00, 20); load(2, 2'b00, 30); load(3, 2'b11, 0);
  endtask

  task do_start;
    @(negedge clk);
    song_time = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
  endtask

  task sweep(input int lo, input int hi);
    exp_t e;
    for (int st = lo; st <= hi; st++) begin
      @(negedge clk);
      song_time = st[TIME_W-1:0];
      e.miss = (st == 23 || st == 33 || st == 43);
      e.head = st >= 43 ? 3'd3 : st >= 33 ? 3'd2 : st >= 23 ? 3'd1 : 3'd0;
      e.done = st >= 44;
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (miss_pulse !== e.miss || head_addr !== e.head || done !== e.done) begin
        errors++;
        $display("FAIL sweep st=%0d got miss=%b head=%0d done=%b want miss=%b head=%0d done=%b",
                 st, miss_pulse, head_addr, done, e.miss, e.head, e.done);
      end
      if (st == 0) begin
        checks++;
        if (win_valid !== 4'b0111 || win_entry !== {16'h0, 16'd30, 16'd20, 16'd10}) begin
          errors++; $display("FAIL win_head0 got v=%b e=%h want v=0111", win_valid, win_entry);
        end
      end
      if (st == 40) begin
        checks++;
        if (win_valid !== 4'b0001 || win_entry !== {48'h0, 16'd30}) begin
          errors++; $display("FAIL win_head2 got v=%b e=%h want v=0001", win_valid, win_entry);
        end
      end
    end
  endtask

  task test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, miss_pulse, hold_active, head_addr, win_valid} !== '0 || win_entry !== '0) begin
      errors++; $display("FAIL reset got busy=%b done=%b head=%0d v=%b want all 0", busy, done, head_addr, win_valid);
    end
    @(negedge clk); rst = 0;
  endtask

  task test_miss_sweep;
    load_chart_a();
    do_start();
    sweep(0, 60);
  endtask

  task test_consume_late;
    do_start();
    sweep(0, 22);
    @(negedge clk); song_time = 23; consume = 1;
    @(posedge clk); #1;
    checks++;
    if (head_addr !== 3'd1 || miss_pulse !== 1'b0) begin
      errors++; $display("FAIL consume_late got head=%0d miss=%b want head=1 miss=0", head_addr, miss_pulse);
    end
    @(negedge clk); consume = 0;
    @(posedge clk); #1;
    checks++;
    if (head_addr !== 3'd1 || miss_pulse !== 1'b0) begin
      errors++; $display("FAIL consume_hold got head=%0d miss=%b want head=1 miss=0", head_addr, miss_pulse);
    end
    @(negedge clk); song_time = 33;
    @(posedge clk); #1;
    checks++;
    if (head_addr !== 3'd2 || miss_pulse !== 1'b1) begin
      errors++; $display("FAIL late_after got head=%0d miss=%b want head=2 miss=1", head_addr, miss_pulse);
    end
    sweep(34, 50);
  endtask

  task test_boundary;
    for (int i = 0; i < DEPTH; i++) load(i, 2'b00, 100);
    do_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); consume = 1;
      @(posedge clk); #1;
      checks++;
      if (head_addr !== 3'(i + 1)) begin
        errors++; $display("FAIL bnd_head got %0d want %0d", head_addr, i + 1);
      end
    end
    @(negedge clk); consume = 0;
    load_we = 1; load_addr = 3'd7; load_data = {2'b11, 14'd0};
    @(negedge clk); load_we = 0;
    @(posedge clk); #1;
    checks++;
    if (win_valid !== 4'b0011 || win_entry[63:32] !== 32'h0 || win_entry[31:0] !== {16'd100, 16'd100}) begin
      errors++; $display("FAIL bnd_window got v=%b e=%h want v=0011", win_valid, win_entry);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); consume = 1;
      @(posedge clk); #1;
    end
    consume = 0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || miss_pulse !== 1'b0) begin
      errors++; $display("FAIL bnd_done got done=%b busy=%b miss=%b want 1 0 0", done, busy, miss_pulse);
    end
  endtask

  task test_reset_mid;
    load_chart_a();
    do_start();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); consume = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (head_addr !== 3'd2) begin errors++; $display("FAIL mid_head got %0d want 2", head_addr); end
    @(negedge clk); rst = 1; song_time = 60;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, miss_pulse, hold_active, head_addr, win_valid} !== '0 || win_entry !== '0) begin
      errors++; $display("FAIL mid_reset got busy=%b done=%b miss=%b head=%0d v=%b want all 0",
                         busy, done, miss_pulse, head_addr, win_valid);
    end
    @(negedge clk); rst = 0; consume = 0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, head_addr, win_valid} !== '0) begin
      errors++; $display("FAIL mid_idle got busy=%b done=%b head=%0d v=%b want 0", busy, done, head_addr, win_valid);
    end
    do_start();
    sweep(0, 60);
  endtask

  task test_hold;
    logic exp_h;
`ifdef CHART_HOLD_EN
    exp_h = 1'b1;
`else
    exp_h = 1'b0;
`endif
    load(0, 2'b01, 10); load(1, 2'b10, 40); load(2, 2'b11, 0);
    do_start();
    @(negedge clk); song_time = 10; consume = 1;
    @(posedge clk); #1;
    consume = 0;
    checks++;
    if (hold_active !== exp_h || head_addr !== 3'd1) begin
      errors++; $display("FAIL hold_set got hold=%b head=%0d want hold=%b head=1", hold_active, head_addr, exp_h);
    end
    for (int st = 11; st <= 53; st++) begin
      @(negedge clk); song_time = st[TIME_W-1:0];
      @(posedge clk); #1;
      checks++;
      if (miss_pulse !== (st == 53)) begin
        errors++; $display("FAIL hold_miss st=%0d got %b want %b", st, miss_pulse, st == 53);
      end
    end
    checks++;
    if (hold_active !== 1'b0 || head_addr !== 3'd2) begin
      errors++; $display("FAIL hold_clear got hold=%b head=%0d want hold=0 head=2", hold_active, head_addr);
    end
  endtask

  initial begin
    test_reset();
    test_miss_sweep();
    test_consume_late();
    test_boundary();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
